// File: rtl/i2c_arbiter_pkg.sv
// Shared definitions for the I2C requester arbiter: FSM encoding, field widths,
// timeout default and the master-side field bundle.
package i2c_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned GID_W   = 2;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned RDATA_W = 16;

  localparam logic [23:0] TIMEOUT_CYC_DEF = 24'd10_000_000;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StRun,
    StCapture,
    StRelease,
    StDone
  } arb_state_e;

  // Everything presented to the I2C master for one transaction.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BYTE_W-1:0] cmd;
    logic              mode;
    logic              num;
    logic              stretch;
    logic [BYTE_W-1:0] wdata;
  } m_fields_t;

  function automatic logic [NUM_REQ-1:0] gid_onehot(input logic [GID_W-1:0] id);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/i2c_arbiter_if.sv
// Requester and I2C-master signal bundle for i2c_arbiter.
// slave: the arbiter's view; master: the environment (requesters + I2C master engine).
interface i2c_arbiter_if;
  import i2c_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*BYTE_W-1:0] req_cmd;
  logic [NUM_REQ*BYTE_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_mode;
  logic [NUM_REQ-1:0]        req_num;
  logic [NUM_REQ-1:0]        req_stretch;
  logic [NUM_REQ-1:0]        ack;
  logic [RDATA_W-1:0]        rdata;
  logic [NUM_REQ-1:0]        err;
  logic                      busy;
  logic [GID_W-1:0]          grant_id;

  logic                      m_set;
  logic [ADDR_W-1:0]         m_addr;
  logic [BYTE_W-1:0]         m_cmd;
  logic                      m_mode;
  logic                      m_num;
  logic                      m_stretch;
  logic [BYTE_W-1:0]         m_wdata;
  logic                      m_finish;
  logic [RDATA_W-1:0]        m_rdata;

  modport slave (
    input  req, req_addr, req_cmd, req_wdata, req_mode, req_num, req_stretch,
    input  m_finish, m_rdata,
    output ack, rdata, err, busy, grant_id,
    output m_set, m_addr, m_cmd, m_mode, m_num, m_stretch, m_wdata
  );

  modport master (
    output req, req_addr, req_cmd, req_wdata, req_mode, req_num, req_stretch,
    output m_finish, m_rdata,
    input  ack, rdata, err, busy, grant_id,
    input  m_set, m_addr, m_cmd, m_mode, m_num, m_stretch, m_wdata
  );

endinterface

// File: rtl/i2c_arbiter_rr_arb4.sv
// Combinational 4-way round-robin picker: search starts one past last_grant.
module rr_arb4
  import i2c_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   last_grant,
  output logic [GID_W-1:0]   winner,
  output logic               valid
);

  logic [GID_W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    winner = last_grant;
    valid  = 1'b0;
    idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last_grant + GID_W'(k);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between four requesters.
// Optional RUN-state timeout with sticky per-requester err flags: define I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned N_REQ       = NUM_REQ,
  parameter logic [23:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic          CLK,
  input logic          RST,
  i2c_arbiter_if.slave bus
);

  arb_state_e         state_q;
  logic [GID_W-1:0]   win_q, grant_q, last_grant_q, rr_winner;
  logic               rr_valid, busy_q, m_set_q, timed_out_q, timeout_hit;
  logic [N_REQ-1:0]   ack_q;
  logic [RDATA_W-1:0] rdata_q;
  m_fields_t          m_q, win_fields;

  rr_arb4 u_rr (
    .req        (bus.req),
    .last_grant (last_grant_q),
    .winner     (rr_winner),
    .valid      (rr_valid)
  );

  // Slice the chosen requester's fields out of the packed request buses.
  always_comb begin
    win_fields.addr    = bus.req_addr[int'(win_q)*ADDR_W +: ADDR_W];
    win_fields.cmd     = bus.req_cmd[int'(win_q)*BYTE_W +: BYTE_W];
    win_fields.wdata   = bus.req_wdata[int'(win_q)*BYTE_W +: BYTE_W];
    win_fields.mode    = bus.req_mode[win_q];
    win_fields.num     = bus.req_num[win_q];
    win_fields.stretch = bus.req_stretch[win_q];
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [23:0]      run_cnt_q;
  logic [N_REQ-1:0] err_q, req_prev_q;

  // run_cnt_q holds (RUN cycles so far - 1); trip on the cycle that exceeds the limit.
  assign timeout_hit = (state_q == StRun) && !bus.m_finish && (run_cnt_q == TIMEOUT_CYC);

  // RUN-cycle counter and sticky error flags, cleared on each requester's req rise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_cnt_q  <= '0;
      err_q      <= '0;
      req_prev_q <= '0;
    end else begin
      req_prev_q <= bus.req;
      run_cnt_q  <= (state_q == StRun) ? run_cnt_q + 24'd1 : '0;
      err_q      <= (err_q & ~(bus.req & ~req_prev_q)) |
                    (timeout_hit ? gid_onehot(grant_q) : '0);
    end
  end

  assign bus.err = err_q;
`else
  logic [23:0] unused_timeout;

  assign unused_timeout = TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
  assign bus.err        = '0;
`endif

  // Transaction sequencer; all outputs registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      win_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= GID_W'(NUM_REQ - 1);
      busy_q       <= 1'b0;
      m_set_q      <= 1'b0;
      m_q          <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      timed_out_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (rr_valid) begin
            win_q   <= rr_winner;
            state_q <= StLatch;
          end
        end
        StLatch: begin
          m_q         <= win_fields;
          grant_q     <= win_q;
          busy_q      <= 1'b1;
          m_set_q     <= 1'b1;
          timed_out_q <= 1'b0;
          state_q     <= StRun;
        end
        StRun: begin
          if (bus.m_finish || timeout_hit) begin
            m_set_q     <= 1'b0;
            timed_out_q <= timeout_hit;
            state_q     <= StCapture;
          end
        end
        StCapture: begin
          if (m_q.mode && !timed_out_q) begin
            rdata_q <= bus.m_rdata;
          end
          state_q <= StRelease;
        end
        StRelease: begin
          if (!bus.m_finish) begin
            ack_q   <= gid_onehot(grant_q);
            state_q <= StDone;
          end
        end
        StDone: begin
          last_grant_q <= grant_q;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;
  assign bus.m_set     = m_set_q;
  assign bus.m_addr    = m_q.addr;
  assign bus.m_cmd     = m_q.cmd;
  assign bus.m_mode    = m_q.mode;
  assign bus.m_num     = m_q.num;
  assign bus.m_stretch = m_q.stretch;
  assign bus.m_wdata   = m_q.wdata;

endmodule
